popcount_window_accumulator: RTL and testbench

- Sequential stage directly downstream of the 16-input population counter.
- Consumes one 5-bit count (0..16) per handshake and sums counts over a window of WINDOW frames.
- Emits the window total through a single-entry registered output slot with valid/ready, plus a threshold flag.
- Supports early window close (flush) and flags out-of-range counts.

---
 rtl/popcount_window_accumulator.sv | 136 +++++++++++++
 tb/tb_popcount_window_accumulator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/popcount_window_accumulator.sv
// Sums popcount beats over a window of WINDOW frames and hands each window total
// to a single-entry registered output slot (valid/ready). Supports early close by flush.
module popcount_window_accumulator #(
  parameter int WINDOW = 8,
  parameter int ACC_W  = 8,
  parameter int THRESH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_valid,
  output logic             cnt_ready,
  input  logic [4:0]       cnt_in,
  input  logic             flush,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic [8:0]       sum_frames,
  output logic             sum_over,
  output logic             sum_partial,
  output logic             err_range
);

  localparam logic [8:0] LAST_FRAME = 9'(WINDOW - 1);
  localparam logic [8:0] FULL_COUNT = 9'(WINDOW);
  localparam logic [4:0] CNT_MAX    = 5'd16;

  function automatic logic [4:0] clamp_cnt(input logic [4:0] c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [4:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-4){1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [8:0]       frame_q, frame_d;
  logic             flush_pend_q, flush_pend_d;
  logic             sum_valid_q, sum_valid_d;
  logic [ACC_W-1:0] sum_out_q, sum_out_d;
  logic [8:0]       sum_frames_q, sum_frames_d;
  logic             sum_over_q, sum_over_d;
  logic             sum_partial_q, sum_partial_d;
  logic             err_q, err_d;

  logic             slot_free;
  logic             last_beat;
  logic             accept;
  logic [ACC_W-1:0] acc_next;
  logic [8:0]       eff_cnt;
  logic             full_close;
  logic             flush_req;
  logic             flush_close;
  logic             close;

  assign slot_free = !sum_valid_q || sum_ready;
  assign last_beat = (frame_q == LAST_FRAME);
  // The closing beat and any beat behind a pending flush must wait for the slot.
  assign cnt_ready = !((last_beat || flush_pend_q) && !slot_free);
  assign accept    = cnt_valid && cnt_ready;
  assign acc_next  = accept ? sat_add(acc_q, clamp_cnt(cnt_in)) : acc_q;
  assign eff_cnt   = frame_q + {8'd0, accept};

  assign full_close  = accept && last_beat;
  assign flush_req   = (flush || flush_pend_q) && (eff_cnt != 9'd0);
  assign flush_close = flush_req && slot_free;
  assign close       = full_close || flush_close;

  always_comb begin
    acc_d         = acc_q;
    frame_d       = frame_q;
    flush_pend_d  = flush_pend_q;
    sum_valid_d   = sum_valid_q;
    sum_out_d     = sum_out_q;
    sum_frames_d  = sum_frames_q;
    sum_over_d    = sum_over_q;
    sum_partial_d = sum_partial_q;
    err_d         = err_q || (accept && (cnt_in > CNT_MAX));

    if (close) begin
      // A close in the same cycle as a drain simply overwrites the slot.
      sum_valid_d   = 1'b1;
      sum_out_d     = acc_next;
      sum_frames_d  = eff_cnt;
      sum_partial_d = (eff_cnt != FULL_COUNT);
      sum_over_d    = (32'(acc_next) >= 32'(THRESH));
      acc_d         = '0;
      frame_d       = '0;
      flush_pend_d  = 1'b0;
    end else begin
      if (sum_valid_q && sum_ready) begin
        sum_valid_d = 1'b0;
      end
      if (accept) begin
        acc_d   = acc_next;
        frame_d = eff_cnt;
      end
      if (flush_req) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q         <= '0;
      frame_q       <= '0;
      flush_pend_q  <= 1'b0;
      sum_valid_q   <= 1'b0;
      sum_out_q     <= '0;
      sum_frames_q  <= '0;
      sum_over_q    <= 1'b0;
      sum_partial_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      frame_q       <= frame_d;
      flush_pend_q  <= flush_pend_d;
      sum_valid_q   <= sum_valid_d;
      sum_out_q     <= sum_out_d;
      sum_frames_q  <= sum_frames_d;
      sum_over_q    <= sum_over_d;
      sum_partial_q <= sum_partial_d;
      err_q         <= err_d;
    end
  end

  assign sum_valid   = sum_valid_q;
  assign sum_out     = sum_out_q;
  assign sum_frames  = sum_frames_q;
  assign sum_over    = sum_over_q;
  assign sum_partial = sum_partial_q;
  assign err_range   = err_q;

endmodule

// File: tb/tb_popcount_window_accumulator.sv
// Directed table-driven bench for popcount_window_accumulator (WINDOW=8, ACC_W=8, THRESH=64).
module tb_popcount_window_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_valid;
  logic       cnt_ready;
  logic [4:0] cnt_in;
  logic       flush;
  logic       sum_valid;
  logic       sum_ready;
  logic [7:0] sum_out;
  logic [8:0] sum_frames;
  logic       sum_over;
  logic       sum_partial;
  logic       err_range;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  popcount_window_accumulator #(.WINDOW(8), .ACC_W(8), .THRESH(64)) dut (
    .clk(clk), .rst(rst), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt_in(cnt_in),
    .flush(flush), .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_out(sum_out),
    .sum_frames(sum_frames), .sum_over(sum_over), .sum_partial(sum_partial),
    .err_range(err_range)
  );

  // Inputs for one cycle plus the outputs expected just before that cycle's edge.
  typedef struct {
    logic       cv;
    logic [4:0] ci;
    logic       fl;
    logic       sr;
    logic       rdy;
    logic       sv;
    int         so;
    int         sf;
    logic       ov;
    logic       pa;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int n, input logic cv, input logic [4:0] ci, input logic fl,
                     input logic sr, input logic rdy, input logic sv, input int so,
                     input int sf, input logic ov, input logic pa, input logic er);
    vec_t v;
    v.cv = cv; v.ci = ci; v.fl = fl; v.sr = sr; v.rdy = rdy; v.sv = sv;
    v.so = so; v.sf = sf; v.ov = ov; v.pa = pa; v.er = er;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic apply_row(input int idx);
    vec_t v;
    string tag;
    v = tbl[idx];
    tag = $sformatf("row%0d", idx);
    cnt_valid = v.cv; cnt_in = v.ci; flush = v.fl; sum_ready = v.sr;
    #1;
    chk({tag, ".cnt_ready"}, int'(cnt_ready), int'(v.rdy));
    chk({tag, ".sum_valid"}, int'(sum_valid), int'(v.sv));
    chk({tag, ".err_range"}, int'(err_range), int'(v.er));
    if (v.sv) begin
      chk({tag, ".sum_out"}, int'(sum_out), v.so);
      chk({tag, ".sum_frames"}, int'(sum_frames), v.sf);
      chk({tag, ".sum_over"}, int'(sum_over), int'(v.ov));
      chk({tag, ".sum_partial"}, int'(sum_partial), int'(v.pa));
    end
    @(negedge clk);
  endtask

  int split;

  initial begin
    // Full window of 16s
    add(8, 1, 16, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1,  1, 1, 128, 8, 1, 0, 0);
    add(1, 0,  0, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    // Backpressure: 16 beats of 1 with sum_ready low
    add(8, 1,  1, 0, 0,  1, 0,   0, 0, 0, 0, 0);
    add(7, 1,  1, 0, 0,  1, 1,   8, 8, 0, 0, 0);
    add(2, 1,  1, 0, 0,  0, 1,   8, 8, 0, 0, 0);
    add(1, 1,  1, 0, 1,  1, 1,   8, 8, 0, 0, 0);
    add(1, 0,  0, 0, 1,  1, 1,   8, 8, 0, 0, 0);
    add(1, 0,  0, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    // Flush without beat, then flush on an empty window
    add(3, 1,  5, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    add(1, 0,  0, 1, 1,  1, 0,   0, 0, 0, 0, 0);
    add(1, 0,  0, 1, 1,  1, 1,  15, 3, 0, 1, 0);
    add(1, 0,  0, 1, 1,  1, 0,   0, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    // Flush together with a beat
    add(2, 1,  3, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    add(1, 1,  3, 1, 1,  1, 0,   0, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1,  1, 1,   9, 3, 0, 1, 0);
    add(1, 0,  0, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    // Flush while the slot is busy
    add(8, 1, 10, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    add(2, 1,  4, 0, 0,  1, 1,  80, 8, 1, 0, 0);
    add(1, 0,  0, 1, 0,  1, 1,  80, 8, 1, 0, 0);
    add(1, 1,  4, 0, 0,  0, 1,  80, 8, 1, 0, 0);
    add(1, 0,  0, 0, 1,  1, 1,  80, 8, 1, 0, 0);
    add(1, 0,  0, 0, 1,  1, 1,   8, 2, 0, 1, 0);
    add(1, 0,  0, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    // Out-of-range count, sticky error
    add(1, 1, 20, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    add(7, 1,  0, 0, 1,  1, 0,   0, 0, 0, 0, 1);
    add(1, 0,  0, 0, 1,  1, 1,  16, 8, 0, 0, 1);
    add(1, 0,  0, 0, 1,  1, 0,   0, 0, 0, 0, 1);
    // Held result plus a 5-beat partial window, then reset
    add(8, 1,  1, 0, 0,  1, 0,   0, 0, 0, 0, 1);
    add(5, 1,  1, 0, 0,  1, 1,   8, 8, 0, 0, 1);
    split = tbl.size();
    // After reset: a fresh window of 2s
    add(7, 1,  2, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    add(1, 1,  2, 0, 1,  1, 0,   0, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1,  1, 1,  16, 8, 0, 0, 0);
    add(1, 0,  0, 0, 1,  1, 0,   0, 0, 0, 0, 0);

    rst = 1'b1; cnt_valid = 1'b0; cnt_in = '0; flush = 1'b0; sum_ready = 1'b0;
    #2;
    chk("reset.sum_valid", int'(sum_valid), 0);
    chk("reset.sum_out", int'(sum_out), 0);
    chk("reset.sum_frames", int'(sum_frames), 0);
    chk("reset.err_range", int'(err_range), 0);
    chk("reset.cnt_ready", int'(cnt_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < split; i++) apply_row(i);

    // Asynchronous reset mid-cycle with a held result and a partial window
    cnt_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async.sum_valid", int'(sum_valid), 0);
    chk("async.sum_out", int'(sum_out), 0);
    chk("async.sum_frames", int'(sum_frames), 0);
    chk("async.sum_over", int'(sum_over), 0);
    chk("async.sum_partial", int'(sum_partial), 0);
    chk("async.err_range", int'(err_range), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = split; i < tbl.size(); i++) apply_row(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
